// File: rtl/mac_fp_pkg.sv
// mac_fp_pkg: shared widths and limits for the SD4 FP16 MAC datapath
package mac_fp_pkg;
  localparam int SUM_W_DEF = 24;
  localparam int EXP_W_DEF = 7;
  localparam int MAN_W_DEF = 11;
  localparam int EXP_MAX = 31;
  localparam int EXP_MIN_FLUSH = -11;
  localparam logic [MAN_W_DEF-1:0] HIDDEN_ONE = 11'h400;
endpackage

// File: rtl/mac_lzc.sv
// mac_lzc: leading-zero count of d (MSB first) with an all-zero flag
module mac_lzc #(
  parameter int W = 23,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  d,
  output logic [CW-1:0] cnt,
  output logic          zero
);
  always_comb begin
    cnt = CW'(W);
    for (int i = 0; i < W; i++) cnt = d[i] ? CW'(W - 1 - i) : cnt;
  end
  assign zero = ~|d;
endmodule

// File: rtl/normalize_round_pipe.sv
// normalize_round_pipe: normalize, RNE-round and saturate/flush the accumulator sum over a 2-stage valid/ready pipe
module normalize_round_pipe
  import mac_fp_pkg::*;
#(
  parameter int SUM_W = SUM_W_DEF,
  parameter int EXP_W = EXP_W_DEF,
  parameter int MAN_W = MAN_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [EXP_W-1:0] in_exp,
  input  logic [SUM_W-1:0] in_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             sign,
  output logic [EXP_W-1:0] exp_final,
  output logic [MAN_W-1:0] norm_sum,
  output logic             ovf
);
  localparam int LZW = $clog2(SUM_W);
  localparam int XW = EXP_W + 1;
  localparam int GB = SUM_W - MAN_W - 1;
  localparam logic [MAN_W-1:0] HIDDEN = {1'b1, {(MAN_W - 1){1'b0}}};
  localparam logic signed [XW-1:0] E_MAX = XW'(EXP_MAX);
  localparam logic signed [XW-1:0] E_MIN = XW'(EXP_MIN_FLUSH);
  logic s2_adv;
  logic [LZW-1:0] lz;
  logic lz_zero, carry;
  logic signed [XW-1:0] e_in, e_n;
  logic [SUM_W-1:0] n_in;
  logic s1_valid, s1_sign, s1_zero;
  logic signed [XW-1:0] s1_exp;
  logic [SUM_W-1:0] s1_norm;
  logic [MAN_W-1:0] m, m_r;
  logic g, st, up, wrap, sat, flush, clear;
  logic signed [XW-1:0] e_r;
  assign s2_adv = ~out_valid | out_ready;
  assign in_ready = ~s1_valid | s2_adv;
  mac_lzc #(.W(SUM_W - 1), .CW(LZW)) u_lzc (
    .d(in_sum[SUM_W-2:0]),
    .cnt(lz),
    .zero(lz_zero)
  );
  // Both paths leave the leading one at the MSB; on carry the dropped LSB stays in the low bits for sticky.
  assign carry = in_sum[SUM_W-1];
  assign n_in = carry ? in_sum : {in_sum[SUM_W-2:0] << lz, 1'b0};
  assign e_in = XW'($signed(in_exp));
  assign e_n = carry ? e_in + XW'(1) : e_in - XW'(lz);
  always_ff @(posedge clk) begin
    if (rst) s1_valid <= 1'b0;
    else if (in_ready) s1_valid <= in_valid;
    if (in_ready && in_valid) begin
      s1_sign <= in_sign;
      s1_zero <= ~carry & lz_zero;
      s1_exp <= e_n;
      s1_norm <= n_in;
    end
  end
  assign m = s1_norm[SUM_W-1 -: MAN_W];
  assign g = s1_norm[GB];
  assign st = |s1_norm[GB-1:0];
  assign up = g & (st | m[0]);
  assign wrap = &m & up;
  assign m_r = wrap ? HIDDEN : m + MAN_W'(up);
  assign e_r = s1_exp + XW'(wrap);
  assign sat = ~s1_zero & (e_r >= E_MAX);
  assign flush = e_r < E_MIN;
  assign clear = s1_zero | flush;
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      sign <= 1'b0;
      exp_final <= '0;
      norm_sum <= '0;
      ovf <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        sign <= s1_sign;
        ovf <= sat;
        exp_final <= sat ? E_MAX[EXP_W-1:0] : clear ? '0 : e_r[EXP_W-1:0];
        norm_sum <= sat ? HIDDEN : clear ? '0 : m_r;
      end
    end
  end
endmodule

// File: tb/tb_normalize_round_pipe.sv
// tb_normalize_round_pipe: directed table, backpressure/reset sequences and a randomized scoreboard run
module tb_normalize_round_pipe;
  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, in_ready, in_sign = 1'b0, out_valid, out_ready = 1'b1;
  logic [6:0] in_exp = '0;
  logic [23:0] in_sum = '0;
  logic sign, ovf;
  logic [6:0] exp_final;
  logic [10:0] norm_sum;
  int checks = 0, errors = 0;
  logic acc;
  logic [19:0] sb[$];

  normalize_round_pipe dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_sign(in_sign),
    .in_exp(in_exp),
    .in_sum(in_sum),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sign(sign),
    .exp_final(exp_final),
    .norm_sum(norm_sum),
    .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    logic sg;
    logic [6:0] e;
    logic [23:0] s;
    logic xs;
    logic [6:0] xe;
    logic [10:0] xm;
    logic xo;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  // Value = s * 2^(e-22); round the 11-bit significand by comparing the discarded remainder to half an ulp.
  function automatic logic [19:0] model(input logic sg, input logic [6:0] e, input logic [23:0] s);
    int p, ex, sh;
    longint q, rem, half;
    if (s == 0) return {sg, 19'd0};
    p = 23;
    while (!s[p]) p--;
    ex = $signed(e) + p - 22;
    sh = p - 10;
    if (sh > 0) begin
      q = longint'(s) >> sh;
      rem = longint'(s) & ((64'd1 << sh) - 1);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q++;
    end else q = longint'(s) << (-sh);
    if (q == 2048) begin
      q = 1024;
      ex++;
    end
    if (ex >= 31) return {sg, 7'd31, 11'h400, 1'b1};
    if (ex < -11) return {sg, 19'd0};
    return {sg, 7'(ex), 11'(q), 1'b0};
  endfunction

  // Call just after driving inputs at a negedge: records the handshakes the next posedge will perform.
  task automatic cycle();
    #1;
    acc = in_valid && in_ready;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) chk("unexpected_beat", 1, 0);
      else chk("stream", {sign, exp_final, norm_sum, ovf}, sb.pop_front());
    end
    if (acc) sb.push_back(model(in_sign, in_exp, in_sum));
  endtask

  task automatic drive(input logic v, input logic sg, input logic [6:0] e, input logic [23:0] s);
    in_valid = v;
    in_sign = sg;
    in_exp = e;
    in_sum = s;
  endtask

  vec_t tbl[17];
  int k, n;
  logic [10:0] held;

  initial begin
    tbl[0]  = '{"pass", 0, 7'd15, 24'h400000, 0, 7'd15, 11'h400, 0};
    tbl[1]  = '{"carry", 0, 7'd15, 24'h800000, 0, 7'd16, 11'h400, 0};
    tbl[2]  = '{"lshift", 0, 7'd20, 24'h001000, 0, 7'd10, 11'h400, 0};
    tbl[3]  = '{"tie_even", 0, 7'd15, 24'h400800, 0, 7'd15, 11'h400, 0};
    tbl[4]  = '{"tie_odd", 0, 7'd15, 24'h401800, 0, 7'd15, 11'h402, 0};
    tbl[5]  = '{"round_wrap", 0, 7'd5, 24'h7FF800, 0, 7'd6, 11'h400, 0};
    tbl[6]  = '{"zero_neg", 1, 7'd10, 24'h000000, 1, 7'd0, 11'h000, 0};
    tbl[7]  = '{"sat31", 0, 7'd31, 24'h400000, 0, 7'd31, 11'h400, 1};
    tbl[8]  = '{"denorm_m5", 0, 7'h7B, 24'h400000, 0, 7'h7B, 11'h400, 0};
    tbl[9]  = '{"flush_m12", 0, 7'h74, 24'h400000, 0, 7'd0, 11'h000, 0};
    tbl[10] = '{"keep_m11", 0, 7'h75, 24'h400000, 0, 7'h75, 11'h400, 0};
    tbl[11] = '{"carry_sat", 1, 7'd30, 24'h800000, 1, 7'd31, 11'h400, 1};
    tbl[12] = '{"carry_sticky", 0, 7'd3, 24'h801001, 0, 7'd4, 11'h401, 0};
    tbl[13] = '{"wrap_sat", 1, 7'd30, 24'h7FF800, 1, 7'd31, 11'h400, 1};
    tbl[14] = '{"flush_neg", 1, 7'h74, 24'h400000, 1, 7'd0, 11'h000, 0};
    tbl[15] = '{"zero_hiexp", 0, 7'd31, 24'h000000, 0, 7'd0, 11'h000, 0};
    tbl[16] = '{"max_lz", 0, 7'd20, 24'h000001, 0, 7'h7E, 11'h400, 0};
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_outputs", {sign, exp_final, norm_sum, ovf}, 0);
    rst = 1'b0;
    foreach (tbl[i]) begin
      @(negedge clk);
      drive(1, tbl[i].sg, tbl[i].e, tbl[i].s);
      #1 chk({tbl[i].name, "_in_ready"}, in_ready, 1);
      @(negedge clk);
      drive(0, 0, 0, 0);
      chk({tbl[i].name, "_early"}, out_valid, 0);
      @(negedge clk);
      chk({tbl[i].name, "_valid"}, out_valid, 1);
      chk(tbl[i].name, {sign, exp_final, norm_sum, ovf}, {tbl[i].xs, tbl[i].xe, tbl[i].xm, tbl[i].xo});
    end
    @(negedge clk);
    // Backpressure: three beats offered while the output is stalled.
    out_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (k < 3) drive(1, k[0], 7'(10 + k), 24'h400000 + 24'(k << 13));
      else drive(0, 0, 0, 0);
      cycle();
      if (acc) k++;
    end
    chk("bp_accepts", k, 2);
    chk("bp_in_ready_low", in_ready, 0);
    held = norm_sum;
    @(negedge clk);
    chk("bp_hold", norm_sum, held);
    out_ready = 1'b1;
    n = 0;
    while ((k < 3 || sb.size() != 0) && n < 20) begin
      cycle();
      if (acc) k++;
      @(negedge clk);
      if (k >= 3) drive(0, 0, 0, 0);
      n++;
    end
    chk("bp_drained", (k == 3 && sb.size() == 0), 1);
    repeat (2) @(negedge clk);
    // Reset with two beats in flight.
    out_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      drive(1, 1, 7'd12, 24'h500000);
    end
    @(negedge clk);
    drive(0, 0, 0, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_flight_valid", out_valid, 0);
    chk("rst_flight_ready", in_ready, 1);
    chk("rst_flight_out", {sign, exp_final, norm_sum, ovf}, 0);
    out_ready = 1'b1;
    n = 0;
    repeat (4) begin
      @(negedge clk);
      n += int'(out_valid);
    end
    chk("rst_no_stale", n, 0);
    // Randomized stream with random valid and ready.
    sb.delete();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid || acc) begin
        case ($urandom_range(0, 9))
          0: in_sum = 24'h0;
          1: in_sum = 24'h800000 | 24'($urandom);
          2: in_sum = {12'($urandom), 12'h800};
          default: in_sum = 24'($urandom) >> $urandom_range(0, 23);
        endcase
        in_valid = ($urandom_range(0, 3) != 0);
        in_sign = 1'($urandom);
        in_exp = 7'($urandom);
      end
      cycle();
    end
    @(negedge clk);
    drive(0, 0, 0, 0);
    out_ready = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < 10) begin
      cycle();
      @(negedge clk);
      n++;
    end
    chk("rand_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
